// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory and fills the IF/ID register.
// A one-entry skid buffer absorbs a response that arrives while decode is stalled.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] target;

    assign target = {BRANCH_TARGET[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = IMEM_ACK ? FETCH : DRAIN;
                end else if (IMEM_ACK) begin
                    pc_d = pc_q + 32'd4;
                    if (!valid_q || !STALL) begin
                        instr_d  = IMEM_RDATA;
                        pc_out_d = addr_q;
                        valid_d  = 1'b1;
                    end else begin
                        skid_instr_d = IMEM_RDATA;
                        skid_pc_d    = addr_q;
                        state_d      = FULL;
                    end
                end else if (!STALL) begin
                    valid_d = 1'b0;
                end
            end
            FULL: begin
                // Leaving FULL on a redirect is what discards the skid entry.
                if (BRANCH_TAKEN) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!STALL) begin
                    instr_d  = skid_instr_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = FETCH;
                end
            end
            DRAIN: begin
                if (BRANCH_TAKEN) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end
                if (IMEM_ACK) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The abandoned request keeps its address on the bus until it is acknowledged.
        addr_d = (state_d == DRAIN) ? addr_q : pc_d;
        req_d  = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= 32'd0;
            pc_out_q     <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            req_q        <= req_d;
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTRUCTION = instr_q;
    assign PC_OUT      = pc_out_q;
    assign PC_PLUS4    = pc_out_q + 32'd4;
    assign VALID       = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a transaction-level model is compared every cycle,
// and directed scenarios pin literal values for streaming, skid, redirects, wrap and async reset.
module tb_instr_fetch;

    logic        clock;
    logic        resetN;
    logic        resetWN;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemAck;
    logic [31:0] imemRdata;

    logic        imemReq,  imemReqW;
    logic [31:0] imemAddr, imemAddrW;
    logic [31:0] instruction, instructionW;
    logic [31:0] pcOut, pcOutW;
    logic [31:0] pcPlus4, pcPlus4W;
    logic        valid, validW;

    int checks   = 0;
    int failures = 0;

    instr_fetch dut (
        .CLK          (clock),
        .RESET_N      (resetN),
        .STALL        (stall),
        .BRANCH_TAKEN (branchTaken),
        .BRANCH_TARGET(branchTarget),
        .IMEM_REQ     (imemReq),
        .IMEM_ADDR    (imemAddr),
        .IMEM_ACK     (imemAck),
        .IMEM_RDATA   (imemRdata),
        .INSTRUCTION  (instruction),
        .PC_OUT       (pcOut),
        .PC_PLUS4     (pcPlus4),
        .VALID        (valid)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .CLK          (clock),
        .RESET_N      (resetWN),
        .STALL        (stall),
        .BRANCH_TAKEN (branchTaken),
        .BRANCH_TARGET(branchTarget),
        .IMEM_REQ     (imemReqW),
        .IMEM_ADDR    (imemAddrW),
        .IMEM_ACK     (imemAck),
        .IMEM_RDATA   (imemRdata),
        .INSTRUCTION  (instructionW),
        .PC_OUT       (pcOutW),
        .PC_PLUS4     (pcPlus4W),
        .VALID        (validW)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Transaction-level model: what has been fetched, what is queued for decode,
    // and whether an abandoned response is still on its way back.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entryT;

    entryT       mSkid[$];
    logic        mStarted;
    logic        mDropping;
    logic [31:0] mDropAddr;
    logic [31:0] mPc;
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mPcOut;

    task automatic modelReset();
        mSkid.delete();
        mStarted  = 1'b0;
        mDropping = 1'b0;
        mDropAddr = 32'd0;
        mPc       = 32'd0;
        mValid    = 1'b0;
        mInstr    = 32'd0;
        mPcOut    = 32'd0;
    endtask

    task automatic modelStep();
        entryT e;
        if (!mStarted) begin
            mStarted = 1'b1;
        end else if (branchTaken) begin
            if (mDropping) begin
                if (imemAck) mDropping = 1'b0;
            end else if (mSkid.size() == 0 && !imemAck) begin
                mDropping = 1'b1;
                mDropAddr = mPc;
            end
            mSkid.delete();
            mValid = 1'b0;
            mPc    = branchTarget & ~32'd3;
        end else if (mDropping) begin
            if (imemAck) mDropping = 1'b0;
        end else if (mSkid.size() != 0) begin
            if (!stall) begin
                e      = mSkid.pop_front();
                mInstr = e.instr;
                mPcOut = e.pc;
                mValid = 1'b1;
            end
        end else if (imemAck) begin
            e.instr = imemRdata;
            e.pc    = mPc;
            mPc     = mPc + 32'd4;
            if (!mValid || !stall) begin
                mInstr = e.instr;
                mPcOut = e.pc;
                mValid = 1'b1;
            end else begin
                mSkid.push_back(e);
            end
        end else if (!stall) begin
            mValid = 1'b0;
        end
    endtask

    // The model advances on the same events as the DUT, including asynchronous reset.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) modelReset();
        else         modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the main DUT against the model on every falling edge once the model is initialised.
    logic modelReady = 1'b0;
    always @(negedge clock) begin
        if (modelReady) begin
            logic expReq;
            expReq = mStarted && (mDropping || mSkid.size() == 0);
            checkOutput("model IMEM_REQ", {31'd0, imemReq}, {31'd0, expReq});
            if (expReq)
                checkOutput("model IMEM_ADDR", imemAddr, mDropping ? mDropAddr : mPc);
            checkOutput("model VALID", {31'd0, valid}, {31'd0, mValid});
            checkOutput("model INSTRUCTION", instruction, mInstr);
            checkOutput("model PC_OUT", pcOut, mPcOut);
            checkOutput("model PC_PLUS4", pcPlus4, mPcOut + 32'd4);
        end
    end

    // Drive one cycle of inputs, then return 1 ns after the edge that consumed them.
    task automatic applyStimulus(input logic s, input logic br, input logic [31:0] tgt,
                                 input logic ack, input logic [31:0] data);
        stall        = s;
        branchTaken  = br;
        branchTarget = tgt;
        imemAck      = ack;
        imemRdata    = data;
        @(posedge clock);
        #1;
    endtask

    logic [1:0] vecTable [12];

    initial begin
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'd0;
        imemAck      = 1'b0;
        imemRdata    = 32'd0;
        resetWN      = 1'b0;
        resetN       = 1'b1;
        #1 resetN    = 1'b0;
        modelReady   = 1'b1;
        #1;

        checkOutput("reset IMEM_REQ", {31'd0, imemReq}, 32'd0);
        checkOutput("reset VALID", {31'd0, valid}, 32'd0);
        checkOutput("reset PC_PLUS4", pcPlus4, 32'd4);
        checkOutput("reset INSTRUCTION", instruction, 32'd0);

        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        resetN = 1'b1;

        // Streaming: ACK high from the start, the IDLE cycle must ignore it.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0013);
        checkOutput("stream first req", {31'd0, imemReq}, 32'd1);
        checkOutput("stream first addr", imemAddr, 32'd0);
        checkOutput("stream idle ack ignored", {31'd0, valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0013);
        checkOutput("stream valid", {31'd0, valid}, 32'd1);
        checkOutput("stream pc_out", pcOut, 32'd0);
        checkOutput("stream next addr", imemAddr, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0093);
        checkOutput("stream pc_out 4", pcOut, 32'd4);

        // Stall with a response for address 8 fills the skid buffer.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hAAAA_0001);
        checkOutput("skid req low", {31'd0, imemReq}, 32'd0);
        checkOutput("skid pc_out held", pcOut, 32'd4);
        checkOutput("skid instr held", instruction, 32'h0040_0093);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'hBADB_AD00);
        checkOutput("full ack ignored", pcOut, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("unskid pc_out", pcOut, 32'd8);
        checkOutput("unskid instr", instruction, 32'hAAAA_0001);
        checkOutput("resume addr", imemAddr, 32'd12);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("consumed valid", {31'd0, valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0011);
        checkOutput("resume pc_out", pcOut, 32'd12);

        // Redirect coinciding with an ACK drops that response.
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'h0000_DEAD);
        checkOutput("redirect ack valid", {31'd0, valid}, 32'd0);
        checkOutput("redirect ack addr", imemAddr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0022);
        checkOutput("redirect target pc_out", pcOut, 32'h0000_0100);

        // Redirect while the request for 0x10 is still pending.
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_DEAD);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
        checkOutput("drain addr held", imemAddr, 32'h0000_0010);
        checkOutput("drain req", {31'd0, imemReq}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checkOutput("drain addr still held", imemAddr, 32'h0000_0010);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0BAD);
        checkOutput("drain dropped valid", {31'd0, valid}, 32'd0);
        checkOutput("drain then target", imemAddr, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0033);
        checkOutput("drain target pc_out", pcOut, 32'h0000_0200);

        // Two redirects during one drain: only the newest target is fetched.
        applyStimulus(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'd0);
        checkOutput("double drain addr", imemAddr, 32'h0000_0204);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0BAD);
        checkOutput("newest target addr", imemAddr, 32'h0000_0500);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0044);

        // Redirect while FULL overrides the stall.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0055);
        applyStimulus(1'b1, 1'b1, 32'h0000_0600, 1'b0, 32'd0);
        checkOutput("full redirect valid", {31'd0, valid}, 32'd0);
        checkOutput("full redirect addr", imemAddr, 32'h0000_0600);

        // Mixed stall/ack pattern checked only by the model.
        vecTable = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecTable[i][1], 1'b0, 32'd0, vecTable[i][0], 32'h0000_1000 + i);
        end

        // Reach FULL again, then reset asynchronously in the middle of a cycle.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0066);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0077);
        checkOutput("pre-reset full", {31'd0, imemReq}, 32'd0);
        #3 resetN = 1'b0;
        #1;
        checkOutput("async VALID", {31'd0, valid}, 32'd0);
        checkOutput("async PC_OUT", pcOut, 32'd0);
        checkOutput("async PC_PLUS4", pcPlus4, 32'd4);
        checkOutput("async INSTRUCTION", instruction, 32'd0);
        checkOutput("async IMEM_REQ", {31'd0, imemReq}, 32'd0);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0099);
        checkOutput("post-reset addr", imemAddr, 32'd0);
        checkOutput("post-reset ack ignored", {31'd0, valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0099);
        checkOutput("post-reset instr", instruction, 32'h0000_0099);

        // Wrap instance starts fetching at the top of the address space.
        resetWN = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0077);
        checkOutput("wrap first addr", imemAddrW, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0077);
        checkOutput("wrap pc_out", pcOutW, 32'hFFFF_FFFC);
        checkOutput("wrap pc_plus4", pcPlus4W, 32'd0);
        checkOutput("wrap next addr", imemAddrW, 32'd0);
        checkOutput("wrap valid", {31'd0, validW}, 32'd1);

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port STALL  input  1  decode cannot accept; hold the IF/ID outputs.
REQ-005 SHALL have port BRANCH_TAKEN  input  1  redirect pulse from execute.
REQ-006 SHALL have port BRANCH_TARGET  input  32  redirect address; bits [1:0] are forced to 0.
REQ-007 SHALL have port IMEM_REQ  output  1  instruction memory request.
REQ-008 SHALL have port IMEM_ADDR  output  32  word-aligned request address.
REQ-009 SHALL have port IMEM_ACK  input  1  one-cycle pulse; IMEM_RDATA is valid in that cycle.
REQ-010 SHALL have port IMEM_RDATA  input  32  fetched instruction word.
REQ-011 SHALL have port INSTRUCTION  output  32  IF/ID instruction, feeding decode and the immediate generator.
REQ-012 SHALL have port PC_OUT  output  32  address of INSTRUCTION.
REQ-013 SHALL have port PC_PLUS4  output  32  PC_OUT+4, modulo 2^32.
REQ-014 SHALL have port VALID  output  1  IF/ID contents are a real instruction.

Function
REQ-015 SHALL implement a state machine with states IDLE, FETCH, FULL and DRAIN.
REQ-016 SHALL make IDLE the reset state; IDLE moves to FETCH on the next clock unconditionally.
REQ-017 SHALL drive IMEM_REQ=1 in FETCH and DRAIN and IMEM_REQ=0 in IDLE and FULL.
REQ-018 SHALL keep IMEM_ADDR equal to the in-flight request address, held stable from request assertion until IMEM_ACK.
REQ-019 SHALL define "accept" as: IMEM_ACK=1 in FETCH with BRANCH_TAKEN=0.
REQ-020 On accept, SHALL advance PC by 4; PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 On accept with (VALID=0 or STALL=0), SHALL load INSTRUCTION=IMEM_RDATA, PC_OUT=request address, VALID=1 on the same edge, giving one cycle from ACK to outputs.
REQ-022 On accept with VALID=1 and STALL=1, SHALL capture the response into a one-entry skid buffer and enter FULL.
REQ-023 In FULL with STALL=0, SHALL move the skid entry into IF/ID (VALID=1) and return to FETCH.
REQ-024 In FETCH with no load and STALL=0, SHALL clear VALID, since decode has consumed the entry.
REQ-025 While STALL=1 and no redirect, SHALL hold INSTRUCTION, PC_OUT and VALID unchanged.
REQ-026 On BRANCH_TAKEN=1 in any state other than IDLE, SHALL set PC=BRANCH_TARGET&~3, clear VALID and discard the skid entry; this overrides STALL.
REQ-027 On BRANCH_TAKEN in FETCH with IMEM_ACK=1 in the same cycle, SHALL discard the response and stay in FETCH, requesting the target next cycle.
REQ-028 On BRANCH_TAKEN in FETCH with IMEM_ACK=0, SHALL enter DRAIN; in DRAIN, IMEM_ACK discards the response and moves to FETCH.
REQ-029 On a further BRANCH_TAKEN during DRAIN, SHALL update PC only; only the newest target is fetched.
REQ-030 On BRANCH_TAKEN in FULL, SHALL return to FETCH.
REQ-031 SHALL ignore IMEM_ACK in IDLE and FULL.

Reset
REQ-032 While RESET_N=0, SHALL hold state=IDLE, PC=RESET_PC, IMEM_REQ=0, INSTRUCTION=0, PC_OUT=0, PC_PLUS4=4, VALID=0 and the skid buffer empty, independent of CLK.
REQ-033 Reset assertion mid-request SHALL abandon the request; an IMEM_ACK arriving after reset release while in IDLE is ignored.

Verification
REQ-034 Scenario, streaming: release reset, ACK every cycle with data 0x00000013 -> IMEM_ADDR 0,4,8,...; PC_OUT=0 with VALID=1 one cycle after the first ACK.
REQ-035 Scenario, stall and skid: STALL=1 with VALID=1 (PC_OUT=4) and ACK for address 8 -> FULL, IMEM_REQ=0, outputs held; STALL=0 -> PC_OUT=8, then fetch resumes at 12.
REQ-036 Scenario, redirect with ACK: BRANCH_TAKEN with target 0x00000103 together with ACK -> response dropped, VALID=0, next IMEM_ADDR=0x00000100.
REQ-037 Scenario, redirect without ACK: redirect to 0x200 while a request for 0x10 is pending -> DRAIN keeps IMEM_ADDR=0x10 until ACK, VALID stays 0, then IMEM_ADDR=0x200.
REQ-038 Scenario, wrap: RESET_PC=0xFFFFFFFC, one ACK -> PC_OUT=0xFFFFFFFC, PC_PLUS4=0, next IMEM_ADDR=0.
REQ-039 Scenario, async reset: assert RESET_N=0 mid-clock while in FULL -> all outputs reach their reset values immediately; first request after release is to RESET_PC.
